// File: rtl/gold_nic_if.sv
// Processor register bus and router PE handshake bundle for gold_nic.
// The slave modport is the NIC; the master modport is the core/router side driving it.
interface gold_nic_if;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    modport slave (
        input  addr,
        input  d_in,
        output d_out,
        input  nicEn,
        input  nicWrEn,
        input  net_si,
        output net_ri,
        input  net_di,
        output net_so,
        input  net_ro,
        output net_do,
        input  net_polarity
    );

    modport master (
        output addr,
        output d_in,
        input  d_out,
        output nicEn,
        output nicWrEn,
        output net_si,
        input  net_ri,
        output net_di,
        input  net_so,
        output net_ro,
        input  net_do,
        output net_polarity
    );
endinterface

// File: rtl/gold_nic.sv
// Network interface controller: one-packet buffer per direction between a memory-mapped
// register view and a gold_router PE port; outbound injection waits for matching polarity.
module gold_nic (
    input logic       clk,
    input logic       reset,
    gold_nic_if.slave bus_io
);

    localparam logic [1:0] AddrInBuf   = 2'b00;
    localparam logic [1:0] AddrInStat  = 2'b01;
    localparam logic [1:0] AddrOutBuf  = 2'b10;
    localparam logic [1:0] AddrOutStat = 2'b11;

    logic [63:0] in_buf_q, in_buf_d;
    logic        in_full_q, in_full_d;
    logic [63:0] out_buf_q, out_buf_d;
    logic        out_full_q, out_full_d;

    logic rd_en, wr_en;
    logic net_ri, net_so;

    assign rd_en = bus_io.nicEn & ~bus_io.nicWrEn;
    assign wr_en = bus_io.nicEn & bus_io.nicWrEn;

    assign net_ri = ~in_full_q;
    // Bit 63 is the VC bit; the packet may only leave on the matching ring phase.
    assign net_so = out_full_q & bus_io.net_ro & (out_buf_q[63] == bus_io.net_polarity);

    assign bus_io.net_ri = net_ri;
    assign bus_io.net_so = net_so;
    assign bus_io.net_do = out_buf_q;

    always_comb begin
        bus_io.d_out = 64'b0;
        if (rd_en) begin
            unique case (bus_io.addr)
                AddrInBuf:   bus_io.d_out = in_buf_q;
                AddrInStat:  bus_io.d_out = {63'b0, in_full_q};
                AddrOutBuf:  bus_io.d_out = 64'b0;
                AddrOutStat: bus_io.d_out = {63'b0, out_full_q};
                default:     bus_io.d_out = 64'b0;
            endcase
        end
    end

    // Capture and read-drain are mutually exclusive: capture requires in_full_q=0.
    always_comb begin
        in_buf_d  = in_buf_q;
        in_full_d = in_full_q;
        if (bus_io.net_si && net_ri) begin
            in_buf_d  = bus_io.net_di;
            in_full_d = 1'b1;
        end else if (rd_en && (bus_io.addr == AddrInBuf) && in_full_q) begin
            in_full_d = 1'b0;
        end
    end

    // A write while full (including the send cycle) is dropped; the buffer keeps its value.
    always_comb begin
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        if (net_so) begin
            out_full_d = 1'b0;
        end else if (wr_en && (bus_io.addr == AddrOutBuf) && !out_full_q) begin
            out_buf_d  = bus_io.d_in;
            out_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf_q   <= 64'b0;
            in_full_q  <= 1'b0;
            out_buf_q  <= 64'b0;
            out_full_q <= 1'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end

endmodule

// File: tb/tb_gold_nic.sv
// Directed, table-driven bench for gold_nic plus hand-written reset sequences.
module tb_gold_nic;

    typedef struct {
        logic [1:0]  addr;
        logic        en;
        logic        we;
        logic [63:0] din;
        logic        si;
        logic [63:0] di;
        logic        ro;
        logic        pol;
        logic [63:0] e_dout;
        logic        e_ri;
        logic        e_so;
        logic [63:0] e_do;
    } vec_t;

    localparam int NumVec = 31;
    localparam logic [63:0] P  = 64'h8000_0000_0000_00A5;
    localparam logic [63:0] Q  = 64'h8000_0000_0000_0042;
    localparam logic [63:0] Q2 = 64'h0000_0000_0000_0077;
    localparam logic [63:0] R  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] S  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] T  = 64'h8000_0000_0000_1111;
    localparam logic [63:0] U  = 64'h0000_0000_0000_2222;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[NumVec];

    gold_nic_if nif ();

    gold_nic dut (
        .clk    (clk),
        .reset  (rst_n),
        .bus_io (nif)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] addr, input logic en, input logic we,
                                input logic [63:0] din, input logic si, input logic [63:0] di,
                                input logic ro, input logic pol, input logic [63:0] e_dout,
                                input logic e_ri, input logic e_so, input logic [63:0] e_do);
        vec_t v;
        v.addr = addr; v.en = en; v.we = we; v.din = din; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.e_dout = e_dout; v.e_ri = e_ri; v.e_so = e_so; v.e_do = e_do;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        nif.addr = v.addr; nif.nicEn = v.en; nif.nicWrEn = v.we; nif.d_in = v.din;
        nif.net_si = v.si; nif.net_di = v.di; nif.net_ro = v.ro; nif.net_polarity = v.pol;
    endtask

    task automatic check_all(input string tag, input logic [63:0] e_dout, input logic e_ri,
                             input logic e_so, input logic [63:0] e_do);
        chk({tag, " d_out"}, nif.d_out, e_dout);
        chk({tag, " net_ri"}, {63'b0, nif.net_ri}, {63'b0, e_ri});
        chk({tag, " net_so"}, {63'b0, nif.net_so}, {63'b0, e_so});
        chk({tag, " net_do"}, nif.net_do, e_do);
    endtask

    initial begin
        //                addr en we din    si di  ro pol | d_out ri so do
        vecs[0]  = mk(2'd1, 1, 0, 64'd0, 0, 64'd0, 0, 0, 64'd0, 1, 0, 64'd0);
        vecs[1]  = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 0, 0, 64'd0, 1, 0, 64'd0);
        vecs[2]  = mk(2'd0, 0, 0, 64'd0, 1, P,     0, 0, 64'd0, 1, 0, 64'd0);
        vecs[3]  = mk(2'd1, 1, 0, 64'd0, 0, 64'd0, 0, 0, 64'd1, 0, 0, 64'd0);
        vecs[4]  = mk(2'd0, 1, 0, 64'd0, 0, 64'd0, 0, 0, P,     0, 0, 64'd0);
        vecs[5]  = mk(2'd1, 1, 0, 64'd0, 0, 64'd0, 0, 0, 64'd0, 1, 0, 64'd0);
        vecs[6]  = mk(2'd0, 1, 0, 64'd0, 0, 64'd0, 0, 0, P,     1, 0, 64'd0);
        vecs[7]  = mk(2'd2, 1, 1, Q,     0, 64'd0, 1, 0, 64'd0, 1, 0, 64'd0);
        vecs[8]  = mk(2'd0, 0, 0, 64'd0, 0, 64'd0, 1, 0, 64'd0, 1, 0, Q);
        vecs[9]  = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 1, 64'd1, 1, 1, Q);
        vecs[10] = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 0, 64'd0, 1, 0, Q);
        vecs[11] = mk(2'd2, 1, 1, Q2,    0, 64'd0, 0, 0, 64'd0, 1, 0, Q);
        vecs[12] = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 0, 0, 64'd1, 1, 0, Q2);
        vecs[13] = mk(2'd2, 1, 1, 64'd1, 0, 64'd0, 0, 0, 64'd0, 1, 0, Q2);
        vecs[14] = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 0, 1, 64'd1, 1, 0, Q2);
        vecs[15] = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 1, 64'd1, 1, 0, Q2);
        vecs[16] = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 0, 64'd1, 1, 1, Q2);
        vecs[17] = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 0, 64'd0, 1, 0, Q2);
        vecs[18] = mk(2'd2, 1, 1, Q,     0, 64'd0, 0, 0, 64'd0, 1, 0, Q2);
        vecs[19] = mk(2'd2, 1, 1, 64'd5, 0, 64'd0, 1, 1, 64'd0, 1, 1, Q);
        vecs[20] = mk(2'd3, 1, 0, 64'd0, 0, 64'd0, 1, 1, 64'd0, 1, 0, Q);
        vecs[21] = mk(2'd0, 0, 0, 64'd0, 1, R,     0, 0, 64'd0, 1, 0, Q);
        vecs[22] = mk(2'd0, 1, 0, 64'd0, 1, S,     0, 0, R,     0, 0, Q);
        vecs[23] = mk(2'd0, 0, 0, 64'd0, 1, S,     0, 0, 64'd0, 1, 0, Q);
        vecs[24] = mk(2'd0, 1, 0, 64'd0, 0, 64'd0, 0, 0, S,     0, 0, Q);
        vecs[25] = mk(2'd0, 0, 0, 64'd0, 1, T,     0, 0, 64'd0, 1, 0, Q);
        vecs[26] = mk(2'd0, 0, 0, 64'd0, 1, U,     0, 0, 64'd0, 0, 0, Q);
        vecs[27] = mk(2'd1, 1, 0, 64'd0, 1, U,     0, 0, 64'd1, 0, 0, Q);
        vecs[28] = mk(2'd0, 1, 0, 64'd0, 1, U,     0, 0, T,     0, 0, Q);
        vecs[29] = mk(2'd1, 1, 0, 64'd0, 0, 64'd0, 0, 0, 64'd0, 1, 0, Q);
        vecs[30] = mk(2'd2, 1, 0, 64'd0, 0, 64'd0, 0, 0, 64'd0, 1, 0, Q);

        // Reset held with random inputs: outputs must stay at reset values.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nif.addr = 2'($urandom); nif.nicEn = 1'($urandom); nif.nicWrEn = 1'($urandom);
            nif.d_in = {$urandom, $urandom}; nif.net_si = 1'($urandom);
            nif.net_di = {$urandom, $urandom}; nif.net_ro = 1'($urandom);
            nif.net_polarity = 1'($urandom);
            #1;
            check_all($sformatf("rst%0d", i), 64'd0, 1'b1, 1'b0, 64'd0);
            @(posedge clk);
            #2;
        end
        drive(mk(2'd0, 0, 0, 64'd0, 0, 64'd0, 0, 0, 64'd0, 1, 0, 64'd0));
        rst_n = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            drive(vecs[i]);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_ri, vecs[i].e_so,
                      vecs[i].e_do);
            @(posedge clk);
            #2;
        end

        // Fill both buffers, then assert reset between edges.
        drive(mk(2'd2, 1, 1, Q2, 1, T, 0, 0, 64'd0, 1, 0, 64'd0));
        @(posedge clk);
        #2;
        drive(mk(2'd1, 1, 0, 64'd0, 1, U, 1, 0, 64'd0, 1, 0, 64'd0));
        #1;
        check_all("pre_rst", 64'd1, 1'b0, 1'b1, Q2);
        rst_n = 1'b0;
        #1;
        nif.addr = 2'd0;
        #1;
        check_all("mid_rst", 64'd0, 1'b1, 1'b0, 64'd0);
        @(posedge clk);
        #2;
        drive(mk(2'd1, 1, 0, 64'd0, 0, 64'd0, 1, 0, 64'd0, 1, 0, 64'd0));
        rst_n = 1'b1;
        #1;
        check_all("post_rst01", 64'd0, 1'b1, 1'b0, 64'd0);
        nif.addr = 2'd3;
        #1;
        chk("post_rst11 d_out", nif.d_out, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
